// File: rtl/ysyx_22040750_axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-channel arbiter and its round-robin picker.
package ysyx_22040750_axi_rd_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_AR_SEND = 3'b010,
      ST_R_WAIT  = 3'b100
   } state_t;

   localparam logic [2:0] SIZE_8B  = 3'b011;
   localparam logic       M_ICACHE = 1'b0;
   localparam logic       M_DCACHE = 1'b1;

endpackage

// File: rtl/ysyx_22040750_axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module ysyx_22040750_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_gnt,
   output logic       o_valid,
   output logic       o_gnt
);

   assign o_valid = |i_req;
   assign o_gnt   = (&i_req) ? ~i_last_gnt : i_req[1];

endmodule

// File: rtl/ysyx_22040750_axi_rd_arbiter.sv
// Shares one downstream AXI4 read channel between icache (m0) and dcache/MMIO (m1),
// one transaction at a time, with R beats steered back to the granted master.
module ysyx_22040750_axi_rd_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   input  logic              I_m0_arvalid,
   input  logic [ADDR_W-1:0] I_m0_araddr,
   input  logic [7:0]        I_m0_arlen,
   input  logic [2:0]        I_m0_arsize,
   output logic              O_m0_arready,
   output logic [DATA_W-1:0] O_m0_rdata,
   output logic              O_m0_rvalid,
   output logic              O_m0_rlast,
   input  logic              I_m0_rready,
   input  logic              I_m1_arvalid,
   input  logic [ADDR_W-1:0] I_m1_araddr,
   input  logic [7:0]        I_m1_arlen,
   input  logic [2:0]        I_m1_arsize,
   output logic              O_m1_arready,
   output logic [DATA_W-1:0] O_m1_rdata,
   output logic              O_m1_rvalid,
   output logic              O_m1_rlast,
   input  logic              I_m1_rready,
   output logic [ADDR_W-1:0] O_mem_araddr,
   output logic [7:0]        O_mem_arlen,
   output logic [2:0]        O_mem_arsize,
   output logic              O_mem_arvalid,
   input  logic              I_mem_arready,
   input  logic [DATA_W-1:0] I_mem_rdata,
   input  logic              I_mem_rvalid,
   input  logic              I_mem_rlast,
   output logic              O_mem_rready
);

   import ysyx_22040750_axi_rd_arbiter_pkg::*;

   state_t            r_state;
   logic              r_gnt;
   logic              r_last_gnt;
   logic [ADDR_W-1:0] r_araddr;
   logic [7:0]        r_arlen;
   logic [2:0]        r_arsize;
   logic              r_m0_arready;
   logic              r_m1_arready;
   logic              r_mem_arvalid;

   logic              w_req_any;
   logic              w_pick;
   logic              w_in_rwait;
   logic              w_rready_sel;
   logic              w_last_hs;

   ysyx_22040750_rr_arb2 u_rr_arb2 (
      .i_req      ({I_m1_arvalid, I_m0_arvalid}),
      .i_last_gnt (r_last_gnt),
      .o_valid    (w_req_any),
      .o_gnt      (w_pick)
   );

   assign w_in_rwait   = (r_state == ST_R_WAIT);
   assign w_rready_sel = (r_gnt == M_DCACHE) ? I_m1_rready : I_m0_rready;
   assign w_last_hs    = I_mem_rvalid & w_rready_sel & I_mem_rlast;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state       <= ST_IDLE;
         r_gnt         <= M_ICACHE;
         r_last_gnt    <= M_DCACHE;
         r_araddr      <= '0;
         r_arlen       <= '0;
         r_arsize      <= '0;
         r_m0_arready  <= 1'b0;
         r_m1_arready  <= 1'b0;
         r_mem_arvalid <= 1'b0;
      end else begin
         r_m0_arready <= 1'b0;
         r_m1_arready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req_any) begin
                  r_gnt         <= w_pick;
                  r_araddr      <= (w_pick == M_DCACHE) ? I_m1_araddr : I_m0_araddr;
                  r_arlen       <= (w_pick == M_DCACHE) ? I_m1_arlen  : I_m0_arlen;
                  r_arsize      <= (w_pick == M_DCACHE) ? I_m1_arsize : I_m0_arsize;
                  r_m0_arready  <= (w_pick == M_ICACHE);
                  r_m1_arready  <= (w_pick == M_DCACHE);
                  r_mem_arvalid <= 1'b1;
                  r_state       <= ST_AR_SEND;
               end
            end
            ST_AR_SEND: begin
               if (I_mem_arready) begin
                  r_mem_arvalid <= 1'b0;
                  r_state       <= ST_R_WAIT;
               end
            end
            ST_R_WAIT: begin
               // Grant is held until the final beat is actually accepted by the master.
               if (w_last_hs) begin
                  r_last_gnt <= r_gnt;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_mem_arvalid <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign O_m0_arready  = r_m0_arready;
   assign O_m1_arready  = r_m1_arready;
   assign O_mem_arvalid = r_mem_arvalid;
   assign O_mem_araddr  = r_araddr;
   assign O_mem_arlen   = r_arlen;
   assign O_mem_arsize  = r_arsize;

   // R path is combinational; outside R_WAIT nothing is accepted or forwarded.
   assign O_mem_rready = w_in_rwait & w_rready_sel;
   assign O_m0_rdata   = I_mem_rdata;
   assign O_m1_rdata   = I_mem_rdata;
   assign O_m0_rvalid  = w_in_rwait & (r_gnt == M_ICACHE) & I_mem_rvalid;
   assign O_m1_rvalid  = w_in_rwait & (r_gnt == M_DCACHE) & I_mem_rvalid;
   assign O_m0_rlast   = w_in_rwait & (r_gnt == M_ICACHE) & I_mem_rlast;
   assign O_m1_rlast   = w_in_rwait & (r_gnt == M_DCACHE) & I_mem_rlast;

   a_no_stray_beat: assert property (@(posedge I_clk) disable iff (!I_rst_n)
      I_mem_rvalid |-> (r_state == ST_R_WAIT));

endmodule
